can_rx_frame: RTL and testbench
===============================

Name: can_rx_frame

Overview:
- Receive-side counterpart of the CAN transmit stage.
- Samples the bus line once per bit tick, removes stuff bits and checks CRC-15 (poly 15'h4599).
- Parses extended frames: SOF, 11-bit base ID, SRR, IDE, 18-bit ext ID, RTR, r1, r0, DLC, data, CRC, delimiters, EOF.
- Presents the decoded frame to the LLC layer, which splits the ID into type, addresses, handshake and sign fields.

Parameters:
- SYNC_STAGES, 2, number of rx_i synchronizer flops (min 2).
- IDLE_BITS, 11, consecutive recessive bits needed for bus integration after reset or error.
- IFS_BITS, 3, recessive intermission bits required after a good EOF before the next SOF is accepted.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; one clock domain; reset is asynchronous and active-low.
- bit_tick_i  in  1  one-clk_i pulse at the bit sample point, from the baud generator.
- rx_i  in  1  raw CAN line; 0 = dominant.
- rx_busy_o  out  1  high from SOF through the end of EOF.
- frame_valid_o  out  1  one-cycle pulse; a good frame is held on the outputs below.
- id_o  out  29  {base ID[10:0], ext ID[17:0]}, MSB received first.
- rtr_o  out  1  received RTR bit.
- dlc_o  out  4  received DLC, raw value 0..15.
- data_o  out  64  first data byte in [63:56]; bytes not received are 0.
- err_o  out  1  one-cycle error pulse.
- err_code_o  out  2  01 stuff, 10 CRC, 11 form; held until the next err_o.

Behaviour:
- Reset:
  - All outputs 0. State = INTEGRATE with counter 0.
  - Synchronizer flops preset to 1 (recessive).
  - Reset asserted mid-frame abandons the frame; no pulse is produced.
- Sampling: bit b = synchronized rx_i, taken only on cycles with bit_tick_i=1. No state changes on other cycles.
- States and transitions:
  - INTEGRATE: count consecutive recessive bits; a dominant bit clears the count. At IDLE_BITS go to IDLE.
  - IDLE: a dominant bit is SOF. Clear CRC, set destuff last=0, run=1, go to ID_A.
  - ID_A: 11 bits.
  - SRR: must be 1, else form error.
  - IDE: must be 1, else form error; standard frames are not supported.
  - ID_B: 18 bits.
  - RTR, R1, R0: 1 bit each; R1 and R0 values are ignored.
  - DLC: 4 bits. Data byte count = 0 if RTR=1, else min(DLC,8).
  - DATA: 8 × byte count bits; skipped when the count is 0.
  - CRC: 15 bits.
  - CRC_DEL: must be 1.
  - ACK_SLOT: either value accepted; this block does not drive ACK.
  - ACK_DEL: must be 1.
  - EOF: 7 bits, all 1. Then IFS.
  - IFS: IFS_BITS recessive bits, then IDLE. A dominant bit during IFS is ignored (it restarts the IFS count).
- Destuffing, active from SOF through the last CRC bit:
  - Track last bit and run length.
  - After 5 equal bits, the next bit is a stuff bit. If it equals last, raise stuff error. Otherwise drop it (no CRC update, no field count) and set run=1, last=b.
  - A stuff bit following the final CRC bit is consumed before CRC_DEL.
  - No destuffing from CRC_DEL onward.
- CRC: shift with crc_next = b ^ crc[14]. Applied to destuffed bits SOF..DATA, then the 15 CRC bits are compared against the register.
  - A mismatch raises a CRC error at CRC_DEL, checked before the delimiter form check.
- Form errors: any fixed-form bit at the wrong value (SRR, IDE, CRC_DEL, ACK_DEL, EOF).
- Error handling: err_o pulses the clk_i after the offending tick, err_code_o is set, rx_busy_o drops, state goes to INTEGRATE. No frame_valid_o for that frame.
- Output update: id_o, rtr_o, dlc_o and data_o update only together with frame_valid_o, one clk_i after the tick of the 7th EOF bit. They are stable otherwise.
- Bit tick arriving during reset release: ignored until rst_i has been high for one clk_i.

Decomposition:
- can_pkg holds:
  - CRC poly 15'h4599.
  - Field lengths 11/18/4/15/7.
  - IDLE/IFS defaults.
  - Error code constants.
  - Rx state enum, shared with the transmit-side state naming.
- Sub-module can_rx_destuff: inputs tick, bit, enable, sof_clear. Outputs bit_valid, bit, stuff_err. Pure run-length logic.

Test Plan:
- Bench model builds stuffed frames. Integrate (11×1), then frame ID=29'h0ABCDE12, RTR=0, DLC=2, data A5 5A, correct CRC, ACK dominant → frame_valid_o one clk after EOF bit 7; id_o=29'h0ABCDE12, dlc_o=2, data_o=64'hA55A_0000_0000_0000, err_o never set.
- ID=0, DLC=0 → many stuff bits; frame accepted with id_o=0, data_o=0. Back-to-back second frame after exactly 3 recessive IFS bits is also accepted.
- Six dominant bits inside ID_A → err_o pulse with err_code_o=01. The following SOF is ignored until 11 recessive bits are seen.
- Valid frame with CRC bit 7 inverted (restuffed) → err_code_o=10 at CRC_DEL; no frame_valid_o.
- CRC_DEL driven dominant → err_code_o=11. Separately, IDE=0 → err_code_o=11.
- rst_i low for 3 clks during DATA → all outputs 0. Next valid frame after integration decodes correctly. Also: DLC=12 with RTR=0 → 8 bytes received, dlc_o=12.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN constants, state naming and CRC-15 helper for the rx/tx stages.
package can_pkg;

   localparam logic [14:0] CRC_POLY = 15'h4599;

   localparam int unsigned ID_A_LEN = 11;
   localparam int unsigned ID_B_LEN = 18;
   localparam int unsigned DLC_LEN  = 4;
   localparam int unsigned CRC_LEN  = 15;
   localparam int unsigned EOF_LEN  = 7;

   localparam int unsigned IDLE_BITS_DEF = 11;
   localparam int unsigned IFS_BITS_DEF  = 3;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_STUFF = 2'b01;
   localparam logic [1:0] ERR_CRC   = 2'b10;
   localparam logic [1:0] ERR_FORM  = 2'b11;

   typedef enum logic [4:0] {
      ST_INTEGRATE,
      ST_IDLE,
      ST_ID_A,
      ST_SRR,
      ST_IDE,
      ST_ID_B,
      ST_RTR,
      ST_R1,
      ST_R0,
      ST_DLC,
      ST_DATA,
      ST_CRC,
      ST_CRC_DEL,
      ST_ACK_SLOT,
      ST_ACK_DEL,
      ST_EOF,
      ST_IFS
   } can_state_e;

   // One CRC-15 shift step for a single destuffed bit.
   function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[14];
      return {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
   endfunction

endpackage

// File: rtl/can_rx_destuff.sv
// Run-length bit destuffer: flags stuff bits for removal and detects stuff errors.
module can_rx_destuff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic bit_i,
   input  logic enable_i,
   input  logic sof_clear_i,
   output logic bit_valid_o,
   output logic bit_o,
   output logic stuff_err_o
);

   logic       last_q, last_d;
   logic [2:0] run_q, run_d;
   logic       stuff_slot;

   assign stuff_slot  = (run_q == 3'd5);
   assign bit_o       = bit_i;
   assign bit_valid_o = tick_i & enable_i & ~stuff_slot;
   assign stuff_err_o = tick_i & enable_i & stuff_slot & (bit_i == last_q);

   // Track last bit value and run length of equal bits.
   always_comb begin
      last_d = last_q;
      run_d  = run_q;
      if (tick_i) begin
         if (sof_clear_i) begin
            last_d = 1'b0;
            run_d  = 3'd1;
         end else if (enable_i) begin
            if (stuff_slot || (bit_i != last_q)) begin
               last_d = bit_i;
               run_d  = 3'd1;
            end else begin
               run_d = run_q + 3'd1;
            end
         end
      end
   end

   // Run-length state register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         last_q <= 1'b1;
         run_q  <= '0;
      end else begin
         last_q <= last_d;
         run_q  <= run_d;
      end
   end

endmodule

// File: rtl/can_rx_frame.sv
// CAN extended-frame receiver: bus integration, destuffing, CRC-15 check and field decode.
module can_rx_frame
   import can_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned IDLE_BITS   = IDLE_BITS_DEF,
   parameter int unsigned IFS_BITS    = IFS_BITS_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bit_tick_i,
   input  logic        rx_i,
   output logic        rx_busy_o,
   output logic        frame_valid_o,
   output logic [28:0] id_o,
   output logic        rtr_o,
   output logic [3:0]  dlc_o,
   output logic [63:0] data_o,
   output logic        err_o,
   output logic [1:0]  err_code_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   tick_en_q;
   logic                   tick, b;

   can_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [14:0] crc_q, crc_d;
   logic [14:0] rxcrc_q, rxcrc_d;
   logic [28:0] idsh_q, idsh_d;
   logic        rtrsh_q, rtrsh_d;
   logic [3:0]  dlcsh_q, dlcsh_d;
   logic [63:0] datash_q, datash_d;
   logic [6:0]  nbits_q, nbits_d;
   logic        busy_q, busy_d;
   logic        fv_q, fv_d;
   logic        err_q, err_d;
   logic [1:0]  ecode_q, ecode_d;
   logic [28:0] id_q, id_d;
   logic        rtr_q, rtr_d;
   logic [3:0]  dlc_q, dlc_d;
   logic [63:0] data_q, data_d;

   logic        ds_en, ds_clr, ds_valid, ds_bit, ds_err;
   logic [3:0]  dlc_new;
   logic        fail;
   logic [1:0]  fcode;

   assign tick = bit_tick_i & tick_en_q;
   assign b    = sync_q[SYNC_STAGES-1];

   assign ds_en  = (state_q >= ST_ID_A) && (state_q <= ST_CRC_DEL);
   assign ds_clr = (state_q == ST_IDLE) && !b;

   assign dlc_new = {dlcsh_q[2:0], ds_bit};

   can_rx_destuff u_destuff (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .tick_i      (tick),
      .bit_i       (b),
      .enable_i    (ds_en),
      .sof_clear_i (ds_clr),
      .bit_valid_o (ds_valid),
      .bit_o       (ds_bit),
      .stuff_err_o (ds_err)
   );

   // Input synchronizer (preset recessive) and tick gating after reset release.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_q    <= '1;
         tick_en_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
         tick_en_q <= 1'b1;
      end
   end

   // Frame FSM next-state, field capture, CRC and error decisions.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      crc_d    = crc_q;
      rxcrc_d  = rxcrc_q;
      idsh_d   = idsh_q;
      rtrsh_d  = rtrsh_q;
      dlcsh_d  = dlcsh_q;
      datash_d = datash_q;
      nbits_d  = nbits_q;
      busy_d   = busy_q;
      fv_d     = 1'b0;
      err_d    = 1'b0;
      ecode_d  = ecode_q;
      id_d     = id_q;
      rtr_d    = rtr_q;
      dlc_d    = dlc_q;
      data_d   = data_q;
      fail     = 1'b0;
      fcode    = ERR_NONE;

      if (ds_err) begin
         fail  = 1'b1;
         fcode = ERR_STUFF;
      end else if (tick) begin
         unique case (state_q)
            ST_INTEGRATE: begin
               if (!b) cnt_d = '0;
               else if (cnt_q == 8'(IDLE_BITS - 1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 8'd1;
            end
            ST_IDLE: begin
               if (!b) begin
                  state_d  = ST_ID_A;
                  cnt_d    = '0;
                  crc_d    = '0;
                  idsh_d   = '0;
                  rtrsh_d  = 1'b0;
                  dlcsh_d  = '0;
                  datash_d = '0;
                  nbits_d  = '0;
                  busy_d   = 1'b1;
               end
            end
            ST_ID_A: if (ds_valid) begin
               crc_d  = crc_step(crc_q, ds_bit);
               idsh_d = {idsh_q[27:0], ds_bit};
               if (cnt_q == 8'(ID_A_LEN - 1)) begin
                  state_d = ST_SRR;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 8'd1;
            end
            ST_SRR: if (ds_valid) begin
               crc_d = crc_step(crc_q, ds_bit);
               if (!ds_bit) begin
                  fail  = 1'b1;
                  fcode = ERR_FORM;
               end else state_d = ST_IDE;
            end
            ST_IDE: if (ds_valid) begin
               crc_d = crc_step(crc_q, ds_bit);
               if (!ds_bit) begin
                  fail  = 1'b1;
                  fcode = ERR_FORM;
               end else begin
                  state_d = ST_ID_B;
                  cnt_d   = '0;
               end
            end
            ST_ID_B: if (ds_valid) begin
               crc_d  = crc_step(crc_q, ds_bit);
               idsh_d = {idsh_q[27:0], ds_bit};
               if (cnt_q == 8'(ID_B_LEN - 1)) begin
                  state_d = ST_RTR;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 8'd1;
            end
            ST_RTR: if (ds_valid) begin
               crc_d   = crc_step(crc_q, ds_bit);
               rtrsh_d = ds_bit;
               state_d = ST_R1;
            end
            ST_R1: if (ds_valid) begin
               crc_d   = crc_step(crc_q, ds_bit);
               state_d = ST_R0;
            end
            ST_R0: if (ds_valid) begin
               crc_d   = crc_step(crc_q, ds_bit);
               state_d = ST_DLC;
               cnt_d   = '0;
            end
            ST_DLC: if (ds_valid) begin
               crc_d   = crc_step(crc_q, ds_bit);
               dlcsh_d = dlc_new;
               if (cnt_q == 8'(DLC_LEN - 1)) begin
                  cnt_d = '0;
                  if (rtrsh_q || (dlc_new == 4'd0)) state_d = ST_CRC;
                  else begin
                     state_d = ST_DATA;
                     nbits_d = (dlc_new > 4'd8) ? 7'd64 : {dlc_new, 3'b000};
                  end
               end else cnt_d = cnt_q + 8'd1;
            end
            ST_DATA: if (ds_valid) begin
               crc_d = crc_step(crc_q, ds_bit);
               datash_d[~cnt_q[5:0]] = ds_bit;
               if (cnt_q == (8'(nbits_q) - 8'd1)) begin
                  state_d = ST_CRC;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 8'd1;
            end
            ST_CRC: if (ds_valid) begin
               rxcrc_d = {rxcrc_q[13:0], ds_bit};
               if (cnt_q == 8'(CRC_LEN - 1)) begin
                  state_d = ST_CRC_DEL;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 8'd1;
            end
            // A pending stuff bit after the last CRC bit is dropped by the destuffer
            // (ds_valid low), so the delimiter is evaluated on the following tick.
            ST_CRC_DEL: if (ds_valid) begin
               if (rxcrc_q != crc_q) begin
                  fail  = 1'b1;
                  fcode = ERR_CRC;
               end else if (!ds_bit) begin
                  fail  = 1'b1;
                  fcode = ERR_FORM;
               end else state_d = ST_ACK_SLOT;
            end
            ST_ACK_SLOT: state_d = ST_ACK_DEL;
            ST_ACK_DEL: begin
               if (!b) begin
                  fail  = 1'b1;
                  fcode = ERR_FORM;
               end else begin
                  state_d = ST_EOF;
                  cnt_d   = '0;
               end
            end
            ST_EOF: begin
               if (!b) begin
                  fail  = 1'b1;
                  fcode = ERR_FORM;
               end else if (cnt_q == 8'(EOF_LEN - 1)) begin
                  fv_d    = 1'b1;
                  busy_d  = 1'b0;
                  id_d    = idsh_q;
                  rtr_d   = rtrsh_q;
                  dlc_d   = dlcsh_q;
                  data_d  = datash_q;
                  state_d = ST_IFS;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 8'd1;
            end
            ST_IFS: begin
               if (!b) cnt_d = '0;
               else if (cnt_q == 8'(IFS_BITS - 1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 8'd1;
            end
            default: state_d = ST_INTEGRATE;
         endcase
      end

      if (fail) begin
         err_d   = 1'b1;
         ecode_d = fcode;
         busy_d  = 1'b0;
         state_d = ST_INTEGRATE;
         cnt_d   = '0;
      end
   end

   // Frame state, shadow fields and registered outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_INTEGRATE;
         cnt_q    <= '0;
         crc_q    <= '0;
         rxcrc_q  <= '0;
         idsh_q   <= '0;
         rtrsh_q  <= 1'b0;
         dlcsh_q  <= '0;
         datash_q <= '0;
         nbits_q  <= '0;
         busy_q   <= 1'b0;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         ecode_q  <= '0;
         id_q     <= '0;
         rtr_q    <= 1'b0;
         dlc_q    <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         crc_q    <= crc_d;
         rxcrc_q  <= rxcrc_d;
         idsh_q   <= idsh_d;
         rtrsh_q  <= rtrsh_d;
         dlcsh_q  <= dlcsh_d;
         datash_q <= datash_d;
         nbits_q  <= nbits_d;
         busy_q   <= busy_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
         ecode_q  <= ecode_d;
         id_q     <= id_d;
         rtr_q    <= rtr_d;
         dlc_q    <= dlc_d;
         data_q   <= data_d;
      end
   end

   assign rx_busy_o     = busy_q;
   assign frame_valid_o = fv_q;
   assign err_o         = err_q;
   assign err_code_o    = ecode_q;
   assign id_o          = id_q;
   assign rtr_o         = rtr_q;
   assign dlc_o         = dlc_q;
   assign data_o        = data_q;

endmodule

// File: tb/tb_can_rx_frame.sv
// Self-checking bench for can_rx_frame: builds stuffed frames and scoreboards output events.
module tb_can_rx_frame;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        tick = 1'b0;
   logic        rx = 1'b1;
   logic        rx_busy_o, frame_valid_o, rtr_o, err_o;
   logic [28:0] id_o;
   logic [3:0]  dlc_o;
   logic [63:0] data_o;
   logic [1:0]  err_code_o;

   typedef struct packed {
      logic [1:0]  kind;   // 1 = frame, 2 = error
      logic [1:0]  code;
      logic [28:0] id;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
   } ev_t;

   ev_t  exp_q[$];
   ev_t  obs_q[$];
   logic txq[$];
   int   checks = 0;
   int   failures = 0;

   can_rx_frame #(.SYNC_STAGES(2), .IDLE_BITS(11), .IFS_BITS(3)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .bit_tick_i    (tick),
      .rx_i          (rx),
      .rx_busy_o     (rx_busy_o),
      .frame_valid_o (frame_valid_o),
      .id_o          (id_o),
      .rtr_o         (rtr_o),
      .dlc_o         (dlc_o),
      .data_o        (data_o),
      .err_o         (err_o),
      .err_code_o    (err_code_o)
   );

   always #5 clk = ~clk;

   // Record every pulse the DUT produces.
   always @(negedge clk) begin
      if (rst_i && frame_valid_o) obs_q.push_back({2'd1, 2'd0, id_o, rtr_o, dlc_o, data_o});
      if (rst_i && err_o)         obs_q.push_back({2'd2, err_code_o, 29'd0, 1'b0, 4'd0, 64'd0});
   end

   task automatic send_bit(input logic b);
      @(negedge clk) rx = b;
      repeat (4) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic send_idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_q();
      while (txq.size() != 0) send_bit(txq.pop_front());
   endtask

   // Build a stuffed extended frame into txq; kind 1/2 pushes the expected event.
   task automatic build_frame(input logic [28:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] data, input logic srr, input logic ide,
                              input logic [14:0] crc_xor, input logic crcdel,
                              input logic [1:0] kind, input logic [1:0] code);
      logic        u[$];
      logic [14:0] crc;
      logic        fb, last;
      int          nb, run;
      logic [63:0] mask;
      crc = '0;
      u.push_back(1'b0);
      for (int i = 28; i >= 18; i--) u.push_back(id[i]);
      u.push_back(srr);
      u.push_back(ide);
      for (int i = 17; i >= 0; i--) u.push_back(id[i]);
      u.push_back(rtr);
      u.push_back(1'b0);
      u.push_back(1'b0);
      for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
      nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
      for (int i = 0; i < nb * 8; i++) u.push_back(data[63 - i]);
      foreach (u[i]) begin
         fb  = u[i] ^ crc[14];
         crc = {crc[13:0], 1'b0};
         if (fb) crc = crc ^ 15'h4599;
      end
      crc = crc ^ crc_xor;
      for (int i = 14; i >= 0; i--) u.push_back(crc[i]);
      last = 1'b1;
      run  = 0;
      foreach (u[i]) begin
         txq.push_back(u[i]);
         if (u[i] == last) run++;
         else begin
            last = u[i];
            run  = 1;
         end
         if (run == 5) begin
            txq.push_back(~u[i]);
            last = ~u[i];
            run  = 1;
         end
      end
      txq.push_back(crcdel);
      txq.push_back(1'b0);
      txq.push_back(1'b1);
      for (int i = 0; i < 7; i++) txq.push_back(1'b1);
      mask = (nb == 0) ? 64'd0 : ~({64{1'b1}} >> (8 * nb));
      if (kind == 2'd1) exp_q.push_back({2'd1, 2'd0, id, rtr, dlc, data & mask});
      if (kind == 2'd2) exp_q.push_back({2'd2, code, 29'd0, 1'b0, 4'd0, 64'd0});
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (frame_valid_o !== 1'b0) begin failures++; $display("FAIL reset_fv got %b want 0", frame_valid_o); end
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err_o); end
      checks++; if (rx_busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", rx_busy_o); end
      checks++; if ({id_o, rtr_o, dlc_o, data_o, err_code_o} !== '0) begin
         failures++; $display("FAIL reset_fields got id=%h rtr=%b dlc=%h data=%h code=%b want all 0", id_o, rtr_o, dlc_o, data_o, err_code_o);
      end
      rst_i = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      ev_t e, o;
      int  n;
      send_idle(11);
      build_frame(29'h0ABCDE12, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 1'b1, 15'h0, 1'b1, 2'd1, 2'd0);
      n = 0;
      while (txq.size() != 0) begin
         send_bit(txq.pop_front());
         n++;
         if (n == 10) begin
            checks++; if (rx_busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy got %b want 1", rx_busy_o); end
         end
      end
      checks++; if (frame_valid_o !== 1'b1) begin failures++; $display("FAIL basic_fv_timing got %b want 1", frame_valid_o); end
      @(negedge clk);
      checks++; if (frame_valid_o !== 1'b0) begin failures++; $display("FAIL basic_fv_pulse got %b want 0", frame_valid_o); end
      checks++; if (data_o !== 64'hA55A_0000_0000_0000) begin failures++; $display("FAIL basic_data_hold got %h want a55a000000000000", data_o); end
      repeat (3) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL basic missing event got none want %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL basic event got %h want %h", o, e); end
         end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL basic extra events got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_back_to_back();
      ev_t e, o;
      send_idle(11);
      build_frame(29'h0, 1'b0, 4'd0, 64'h0, 1'b1, 1'b1, 15'h0, 1'b1, 2'd1, 2'd0);
      send_q();
      send_idle(3);
      build_frame(29'h1FFFFFFF, 1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 15'h0, 1'b1, 2'd1, 2'd0);
      send_q();
      repeat (3) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL b2b missing event got none want %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL b2b event got %h want %h", o, e); end
         end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL b2b extra events got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_stuff_error();
      ev_t e, o;
      send_idle(11);
      exp_q.push_back({2'd2, 2'b01, 29'd0, 1'b0, 4'd0, 64'd0});
      for (int i = 0; i < 6; i++) send_bit(1'b0);
      checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL stuff_err_timing got %b want 1", err_o); end
      send_bit(1'b0);
      checks++; if (rx_busy_o !== 1'b0) begin failures++; $display("FAIL stuff_busy_drop got %b want 0", rx_busy_o); end
      send_idle(5);
      build_frame(29'h0ABCDE12, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 1'b1, 15'h0, 1'b1, 2'd0, 2'd0);
      send_q();
      send_idle(11);
      build_frame(29'h00012345, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 1'b1, 1'b1, 15'h0, 1'b1, 2'd1, 2'd0);
      send_q();
      checks++; if (err_code_o !== 2'b01) begin failures++; $display("FAIL stuff_code_hold got %b want 01", err_code_o); end
      repeat (3) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL stuff missing event got none want %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL stuff event got %h want %h", o, e); end
         end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL stuff extra events got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_crc_error();
      ev_t e, o;
      send_idle(11);
      build_frame(29'h0ABCDE12, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 1'b1, 15'h0080, 1'b1, 2'd2, 2'b10);
      send_q();
      repeat (3) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL crc missing event got none want %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL crc event got %h want %h", o, e); end
         end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL crc extra events got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_form_errors();
      ev_t e, o;
      send_idle(11);
      build_frame(29'h05555555, 1'b0, 4'd1, 64'h8100_0000_0000_0000, 1'b1, 1'b1, 15'h0, 1'b0, 2'd2, 2'b11);
      send_q();
      send_idle(11);
      build_frame(29'h0ABCDE12, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 1'b0, 15'h0, 1'b1, 2'd2, 2'b11);
      send_q();
      repeat (3) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL form missing event got none want %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL form event got %h want %h", o, e); end
         end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL form extra events got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_reset_midframe();
      send_idle(11);
      build_frame(29'h0ABCDE12, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 15'h0, 1'b1, 2'd0, 2'd0);
      for (int i = 0; i < 55; i++) send_bit(txq.pop_front());
      txq.delete();
      @(negedge clk) rst_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({rx_busy_o, frame_valid_o, err_o} !== 3'b000) begin
         failures++; $display("FAIL midreset_flags got busy=%b fv=%b err=%b want 000", rx_busy_o, frame_valid_o, err_o);
      end
      checks++; if ({id_o, rtr_o, dlc_o, data_o, err_code_o} !== '0) begin
         failures++; $display("FAIL midreset_fields got id=%h dlc=%h data=%h code=%b want all 0", id_o, dlc_o, data_o, err_code_o);
      end
      rx = 1'b1;
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL midreset extra events got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_dlc12();
      ev_t e, o;
      send_idle(11);
      build_frame(29'h1555AAAA, 1'b0, 4'd12, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 15'h0, 1'b1, 2'd1, 2'd0);
      send_q();
      repeat (3) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL dlc12 missing event got none want %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL dlc12 event got %h want %h", o, e); end
         end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL dlc12 extra events got %0d want 0", obs_q.size()); obs_q.delete(); end
      checks++; if (dlc_o !== 4'd12) begin failures++; $display("FAIL dlc12_dlc got %0d want 12", dlc_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stuff_error();
      test_crc_error();
      test_form_errors();
      test_reset_midframe();
      test_dlc12();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
